// File: rtl/alu_driver_if.sv
// Request/response channel between instruction issue and the ALU driver.
// The master side issues operations and consumes responses; the slave side
// is the driver itself.
interface alu_driver_if #(
    parameter int WORD_SIZE = 32
);
    // Request channel
    logic                 req_valid;
    logic                 req_ready;
    logic [WORD_SIZE-1:0] req_a;
    logic [WORD_SIZE-1:0] req_b;
    logic [3:0]           req_control;

    // Response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_result;
    logic                 rsp_zero;
    logic                 rsp_cout;
    logic                 rsp_overflow;
    logic                 rsp_err_invalid;
    logic                 rsp_timeout;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_control,
        input  req_ready,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_zero,
        input  rsp_cout,
        input  rsp_overflow,
        input  rsp_err_invalid,
        input  rsp_timeout,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_control,
        output req_ready,
        output rsp_valid,
        output rsp_result,
        output rsp_zero,
        output rsp_cout,
        output rsp_overflow,
        output rsp_err_invalid,
        output rsp_timeout,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_driver.sv
// Sequencing front end for alu_32: accepts one operation at a time, pulses
// the ALU start, waits (bounded) for finished and returns the captured
// result and flags over a valid/ready response channel. Saturating debug
// counters track completed operations and errored/overflowed ones.
module alu_driver #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_driver_if.slave          bus,

    // ALU side
    output logic                 alu_start,
    output logic [WORD_SIZE-1:0] alu_input_a,
    output logic [WORD_SIZE-1:0] alu_input_b,
    output logic [3:0]           alu_control,
    input  logic                 alu_finished,
    input  logic                 alu_zero,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    input  logic                 alu_err_invalid_control,
    input  logic [WORD_SIZE-1:0] alu_result,

    // Debug counters
    output logic [15:0]          ops_done,
    output logic [15:0]          errs_seen
);

    // The counter only has to reach TIMEOUT-1; the FSM leaves WAIT before
    // it could ever wrap.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;

    // Operand registers held on the ALU inputs
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [3:0]           ctl_q, ctl_d;

    // Cycles spent in WAIT
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Response registers
    logic [WORD_SIZE-1:0] res_q, res_d;
    logic                 zero_q, zero_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;

    // Debug counters
    logic [15:0]          ops_q, ops_d;
    logic [15:0]          errs_q, errs_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and timeout counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            ctl_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            ctl_q <= ctl_d;
            cnt_q <= cnt_d;
        end
    end

    // Response capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            tmo_q  <= tmo_d;
        end
    end

    // Saturating debug counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ops_q  <= '0;
            errs_q <= '0;
        end else begin
            ops_q  <= ops_d;
            errs_q <= errs_d;
        end
    end

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        ctl_d         = ctl_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        zero_d        = zero_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        ops_d         = ops_q;
        errs_d        = errs_q;
        alu_start     = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    ctl_d   = bus.req_control;
                    state_d = S_START;
                end
            end

            S_START: begin
                alu_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                // A finish in the last allowed cycle still wins over timeout.
                if (alu_finished) begin
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    cout_d  = alu_cout;
                    ovf_d   = alu_overflow;
                    err_d   = alu_err_invalid_control;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    zero_d  = 1'b0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    ops_d = sat_inc(ops_q);
                    if (err_q || tmo_q || ovf_q) begin
                        errs_d = sat_inc(errs_q);
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alu_input_a         = a_q;
    assign alu_input_b         = b_q;
    assign alu_control         = ctl_q;

    assign bus.rsp_result      = res_q;
    assign bus.rsp_zero        = zero_q;
    assign bus.rsp_cout        = cout_q;
    assign bus.rsp_overflow    = ovf_q;
    assign bus.rsp_err_invalid = err_q;
    assign bus.rsp_timeout     = tmo_q;

    assign ops_done            = ops_q;
    assign errs_seen           = errs_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a small cycle-level stand-in for alu_32
// whose finish delay and returned values are set per vector.
module tb_alu_driver;

    localparam int WS = 32;

    localparam logic [3:0] C_AND  = 4'h0;
    localparam logic [3:0] C_ADD  = 4'h2;
    localparam logic [3:0] C_ADDU = 4'h3;
    localparam logic [3:0] C_SUB  = 4'h6;
    localparam logic [3:0] C_BAD  = 4'hF;

    logic          clock = 1'b0;
    logic          reset = 1'b1;

    logic          alu_start;
    logic [WS-1:0] alu_input_a;
    logic [WS-1:0] alu_input_b;
    logic [3:0]    alu_control;
    logic          alu_finished;
    logic          alu_zero;
    logic          alu_cout;
    logic          alu_overflow;
    logic          alu_err_invalid_control;
    logic [WS-1:0] alu_result;
    logic [15:0]   ops_done;
    logic [15:0]   errs_seen;

    alu_driver_if #(.WORD_SIZE(WS)) bus ();

    alu_driver #(.WORD_SIZE(WS), .TIMEOUT(16)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .bus                     (bus),
        .alu_start               (alu_start),
        .alu_input_a             (alu_input_a),
        .alu_input_b             (alu_input_b),
        .alu_control             (alu_control),
        .alu_finished            (alu_finished),
        .alu_zero                (alu_zero),
        .alu_cout                (alu_cout),
        .alu_overflow            (alu_overflow),
        .alu_err_invalid_control (alu_err_invalid_control),
        .alu_result              (alu_result),
        .ops_done                (ops_done),
        .errs_seen               (errs_seen)
    );

    always #5 clock = ~clock;

    // ALU stand-in: finishes fin_delay cycles after the start cycle
    // (0 = never). Outside the finish cycle it drives inverted values so a
    // capture at the wrong time is visible.
    int            fin_delay = 1;
    int            wait_cnt  = 0;
    int            starts    = 0;
    logic          force_fin = 1'b0;
    logic [WS-1:0] m_res     = '0;
    logic          m_z = 1'b0, m_c = 1'b0, m_o = 1'b0, m_e = 1'b0;

    always @(posedge clock) begin
        if (alu_start) begin
            starts   <= starts + 1;
            wait_cnt <= 1;
        end else if (wait_cnt != 0 && wait_cnt < 1000) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign alu_finished            = force_fin || ((fin_delay > 0) && (wait_cnt == fin_delay));
    assign alu_result              = alu_finished ? m_res : ~m_res;
    assign alu_zero                = alu_finished ? m_z : ~m_z;
    assign alu_cout                = alu_finished ? m_c : ~m_c;
    assign alu_overflow            = alu_finished ? m_o : ~m_o;
    assign alu_err_invalid_control = alu_finished ? m_e : ~m_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input int dly, input logic [WS-1:0] r,
                           input logic z, input logic c, input logic o, input logic e);
        fin_delay = dly;
        m_res = r;
        m_z = z;
        m_c = c;
        m_o = o;
        m_e = e;
    endtask

    // Called at a negedge; returns at the negedge of the START cycle.
    task automatic issue(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic [3:0] c);
        int n;
        bus.req_valid   = 1'b1;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_control = c;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_bound", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    // lat = cycle index of the first rsp_valid cycle, acceptance cycle = 0.
    task automatic wait_rsp(input int limit, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < limit) begin
            @(negedge clock);
            lat++;
        end
        check("rsp_valid_bound", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int s0;

        bus.req_valid   = 1'b0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_control = '0;
        bus.rsp_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_alu_start", {31'd0, alu_start}, 32'd0);
        check("rst_alu_a", alu_input_a, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_ops", {16'd0, ops_done}, 32'd0);
        check("rst_errs", {16'd0, errs_seen}, 32'd0);

        // ADD with signed overflow, ALU finishes one cycle after start
        set_alu(1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h7FFFFFFF, 32'h00000001, C_ADD);
        check("add_start", {31'd0, alu_start}, 32'd1);
        check("add_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("add_alu_a", alu_input_a, 32'h7FFFFFFF);
        check("add_alu_b", alu_input_b, 32'h00000001);
        check("add_alu_ctl", {28'd0, alu_control}, {28'd0, C_ADD});
        wait_rsp(40, lat);
        check("add_latency", lat, 32'd3);
        check("add_result", bus.rsp_result, 32'h80000000);
        check("add_ovf", {31'd0, bus.rsp_overflow}, 32'd1);
        check("add_zero", {31'd0, bus.rsp_zero}, 32'd0);
        check("add_tmo", {31'd0, bus.rsp_timeout}, 32'd0);
        take_rsp();
        check("add_idle", {31'd0, bus.rsp_valid}, 32'd0);
        check("add_ops", {16'd0, ops_done}, 32'd1);
        check("add_errs", {16'd0, errs_seen}, 32'd1);

        // AND giving zero
        set_alu(1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(32'h0000FF00, 32'h000000FF, C_AND);
        wait_rsp(40, lat);
        check("and_result", bus.rsp_result, 32'd0);
        check("and_zero", {31'd0, bus.rsp_zero}, 32'd1);
        check("and_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
        take_rsp();
        check("and_ops", {16'd0, ops_done}, 32'd2);
        check("and_errs", {16'd0, errs_seen}, 32'd1);

        // Invalid control code, forwarded unchanged
        set_alu(1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
        s0 = starts;
        issue(32'h00000011, 32'h00000022, C_BAD);
        check("bad_alu_ctl", {28'd0, alu_control}, 32'h0000000F);
        wait_rsp(40, lat);
        check("bad_err", {31'd0, bus.rsp_err_invalid}, 32'd1);
        check("bad_starts", starts - s0, 32'd1);
        take_rsp();
        check("bad_ops", {16'd0, ops_done}, 32'd3);
        check("bad_errs", {16'd0, errs_seen}, 32'd2);

        // ALU never finishes
        set_alu(0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h00000001, 32'h00000002, C_ADD);
        wait_rsp(60, lat);
        check("tmo_after_start", lat - 1, 32'd17);
        check("tmo_flag", {31'd0, bus.rsp_timeout}, 32'd1);
        check("tmo_result", bus.rsp_result, 32'd0);
        check("tmo_zero", {31'd0, bus.rsp_zero}, 32'd0);
        check("tmo_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
        check("tmo_cout", {31'd0, bus.rsp_cout}, 32'd0);
        // Late finish while the response is pending
        set_alu(0, 32'hCAFE0000, 1'b1, 1'b1, 1'b1, 1'b1);
        force_fin = 1'b1;
        @(negedge clock);
        force_fin = 1'b0;
        check("late_result", bus.rsp_result, 32'd0);
        check("late_tmo", {31'd0, bus.rsp_timeout}, 32'd1);
        check("late_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
        check("late_valid", {31'd0, bus.rsp_valid}, 32'd1);
        take_rsp();
        check("tmo_ops", {16'd0, ops_done}, 32'd4);
        check("tmo_errs", {16'd0, errs_seen}, 32'd3);
        // Stray finish while idle
        force_fin = 1'b1;
        @(negedge clock);
        force_fin = 1'b0;
        @(negedge clock);
        check("stray_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("stray_ready", {31'd0, bus.req_ready}, 32'd1);

        // SUB with response backpressure and a queued second request
        set_alu(1, 32'd3087, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(32'd4321, 32'd1234, C_SUB);
        check("sub_alu_ctl", {28'd0, alu_control}, {28'd0, C_SUB});
        wait_rsp(40, lat);
        check("sub_result", bus.rsp_result, 32'd3087);
        set_alu(1, 32'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req_valid   = 1'b1;
        bus.req_a       = 32'd5;
        bus.req_b       = 32'd6;
        bus.req_control = C_ADDU;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result", bus.rsp_result, 32'd3087);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("hs_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("hs_no_start", {31'd0, alu_start}, 32'd0);
        check("hs_alu_a_held", alu_input_a, 32'd4321);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("q2_start", {31'd0, alu_start}, 32'd1);
        check("q2_alu_a", alu_input_a, 32'd5);
        check("q2_alu_ctl", {28'd0, alu_control}, {28'd0, C_ADDU});
        wait_rsp(40, lat);
        check("q2_result", bus.rsp_result, 32'd11);
        take_rsp();
        check("q2_ops", {16'd0, ops_done}, 32'd6);
        check("q2_errs", {16'd0, errs_seen}, 32'd3);

        // Reset during WAIT, finish arrives the following cycle
        set_alu(2, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(32'hFFFF0000, 32'h0000FFFF, C_ADD);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("arst_ops", {16'd0, ops_done}, 32'd0);
        check("arst_alu_a", alu_input_a, 32'd0);
        check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("prst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("prst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("prst_alu_start", {31'd0, alu_start}, 32'd0);
        check("prst_alu_b", alu_input_b, 32'd0);
        check("prst_alu_ctl", {28'd0, alu_control}, 32'd0);
        check("prst_result", bus.rsp_result, 32'd0);
        check("prst_flags", {27'd0, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow,
                             bus.rsp_err_invalid, bus.rsp_timeout}, 32'd0);
        check("prst_ops", {16'd0, ops_done}, 32'd0);
        check("prst_errs", {16'd0, errs_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed stuck, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
